// File: rtl/regfile_wb_if.sv
// Writeback bus between the two requesters (ALU result A, load result B) and the
// register-file write-port arbiter. The master drives requests; the slave is the arbiter.
interface regfile_wb_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          STALL;
  logic          A_VALID;
  logic [AW-1:0] A_DR;
  logic [DW-1:0] A_DATA;
  logic          A_READY;
  logic          B_VALID;
  logic [AW-1:0] B_DR;
  logic [DW-1:0] B_DATA;
  logic          B_READY;
  logic          RegW;
  logic [AW-1:0] DR;
  logic [DW-1:0] Reg_In;
  logic          LAST_GNT;

  modport master (
    output STALL, A_VALID, A_DR, A_DATA, B_VALID, B_DR, B_DATA,
    input  A_READY, B_READY, RegW, DR, Reg_In, LAST_GNT
  );

  modport slave (
    input  STALL, A_VALID, A_DR, A_DATA, B_VALID, B_DR, B_DATA,
    output A_READY, B_READY, RegW, DR, Reg_In, LAST_GNT
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port. Requester A
// (ALU) and B (load) compete; one write is accepted per cycle and presented to
// the register file one cycle later through registered RegW/DR/Reg_In.
module regfile_wb_arbiter #(
  parameter int DW          = 32,
  parameter int AW          = 5,
  parameter bit SUPPRESS_R0 = 1'b1
) (
  input logic        CLK,
  input logic        RST,
  regfile_wb_if.slave bus
);

  logic          w_gnt_a;
  logic          w_gnt_b;
  logic          r_regw_p1;
  logic [AW-1:0] r_dr_p1;
  logic [DW-1:0] r_reg_in_p1;
  logic          r_last_gnt;

  // R0 is hard-wired zero in the register file when suppression is enabled:
  // the transfer is still accepted, only the write enable is withheld.
  function automatic logic f_write_en(input logic [AW-1:0] dr);
    return !(SUPPRESS_R0 && (dr == '0));
  endfunction

  // Grant: stall blocks everything; a lone requester wins; a tie goes to the
  // requester opposite the last grant. Reset also holds grants off so no
  // requester sees a handshake that the cleared write port would drop.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (!RST && !bus.STALL) begin
      if (bus.A_VALID && bus.B_VALID) begin
        if (r_last_gnt) w_gnt_a = 1'b1;
        else            w_gnt_b = 1'b1;
      end else if (bus.A_VALID) begin
        w_gnt_a = 1'b1;
      end else if (bus.B_VALID) begin
        w_gnt_b = 1'b1;
      end
    end
  end

  // p0 -> p1: capture the granted write; idle or stalled edges drop RegW and
  // leave DR/Reg_In holding the previous write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_regw_p1   <= 1'b0;
      r_dr_p1     <= '0;
      r_reg_in_p1 <= '0;
      r_last_gnt  <= 1'b1;
    end else if (w_gnt_a) begin
      r_regw_p1   <= f_write_en(bus.A_DR);
      r_dr_p1     <= bus.A_DR;
      r_reg_in_p1 <= bus.A_DATA;
      r_last_gnt  <= 1'b0;
    end else if (w_gnt_b) begin
      r_regw_p1   <= f_write_en(bus.B_DR);
      r_dr_p1     <= bus.B_DR;
      r_reg_in_p1 <= bus.B_DATA;
      r_last_gnt  <= 1'b1;
    end else begin
      r_regw_p1   <= 1'b0;
    end
  end

  assign bus.A_READY  = w_gnt_a;
  assign bus.B_READY  = w_gnt_b;
  assign bus.RegW     = r_regw_p1;
  assign bus.DR       = r_dr_p1;
  assign bus.Reg_In   = r_reg_in_p1;
  assign bus.LAST_GNT = r_last_gnt;

endmodule
